aud_cmd_seq: RTL and testbench

- Programmable audio-DSP command sequencer; successor to the fixed three-command feature-extract sequencer.
- Replaces the hardwired command ROM with a DEPTH-entry writable command RAM.
- Runs a command list from a programmable start address, repeats it once per channel for up to NUM_CH channels, and uses an explicit done handshake with the DSP core.
- Sits between the register bank and the DSP datapath control.

---
 rtl/aud_dsp_pkg.sv | 33 +++
 rtl/aud_cmd_ram.sv | 31 +++
 rtl/aud_cmd_seq.sv | 141 ++++++++++++++
 tb/tb_aud_cmd_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_dsp_pkg.sv
// Shared audio-DSP definitions: command field layout, opcodes and sequencer states.
package aud_dsp_pkg;

    // Command payload field positions (bit offsets inside the CMD_W payload)
    localparam int OP_LSB       = 0;
    localparam int OP_MSB       = 5;
    localparam int SEL_MODE_BIT = 6;
    localparam int SEL_BIT      = 7;
    localparam int QUANT_LSB    = 8;
    localparam int QUANT_MSB    = 13;
    localparam int IN_OFF_LSB   = 14;
    localparam int IN_OFF_MSB   = 21;
    localparam int OUT_OFF_LSB  = 22;
    localparam int OUT_OFF_MSB  = 29;
    localparam int COEF_OFF_LSB = 30;
    localparam int COEF_OFF_MSB = 37;
    localparam int PARAM0_LSB   = 38;
    localparam int PARAM0_MSB   = 69;

    // Opcodes carried in the OP field
    localparam logic [5:0] OP_FFT    = 6'h20;
    localparam logic [5:0] OP_MFCC   = 6'h04;
    localparam logic [5:0] OP_HAMWIN = 6'h00;
    localparam logic [5:0] OP_SEQ    = 6'h30;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT
    } cmd_seq_state_t;

endpackage

// File: rtl/aud_cmd_ram.sv
// Command RAM: synchronous write, registered read with read enable.
// The read register only updates on rd_en, so its output stays stable between reads.
module aud_cmd_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 71,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Storage array: no reset, contents survive a sequencer reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read register: cleared on reset so downstream outputs start at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/aud_cmd_seq.sv
// Programmable command sequencer: walks a command list in RAM, repeats it per
// channel, and handshakes each command with the DSP core via dsp_done.
module aud_cmd_seq
    import aud_dsp_pkg::*;
#(
    parameter int CMD_W  = 70,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH),
    parameter int NUM_CH = 2,
    parameter int CH_W   = $clog2(NUM_CH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_wr_en,
    input  logic [AW-1:0]    cmd_wr_addr,
    input  logic [CMD_W:0]   cmd_wr_data,
    input  logic             seq_start,
    input  logic [AW-1:0]    seq_start_addr,
    input  logic [CH_W-1:0]  seq_ch_num,
    input  logic             seq_abort,
    output logic             seq_busy,
    output logic             seq_done,
    output logic             seq_err,
    output logic             dsp_cmd_start,
    output logic [CMD_W-1:0] dsp_cmd,
    output logic [CH_W-1:0]  dsp_ch,
    input  logic             dsp_done
);

    cmd_seq_state_t  state;
    logic [AW-1:0]   addr;
    logic [AW-1:0]   start_addr;
    logic [CH_W-1:0] ch;
    logic [CH_W-1:0] ch_num;
    logic [CMD_W:0]  rd_data;
    logic [CH_W-1:0] ch_clamp;
    logic [AW-1:0]   addr_inc;
    logic            last;
    logic            ch_last;

    // The RAM read register doubles as the command output register: it loads
    // in LOAD and holds through ISSUE/WAIT until the next LOAD.
    aud_cmd_ram #(
        .DEPTH (DEPTH),
        .W     (CMD_W + 1),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cmd_wr_en && !seq_busy),
        .wr_addr (cmd_wr_addr),
        .wr_data (cmd_wr_data),
        .rd_en   (state == ST_LOAD),
        .rd_addr (addr),
        .rd_data (rd_data)
    );

    assign dsp_cmd = rd_data[CMD_W-1:0];
    assign last    = rd_data[CMD_W];
    assign ch_last = (ch == ch_num - CH_W'(1));
    assign addr_inc = (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);

    // Channel count: 0 means one channel, anything above NUM_CH saturates
    always_comb begin
        ch_clamp = seq_ch_num;
        if (seq_ch_num == '0)                 ch_clamp = CH_W'(1);
        else if (seq_ch_num > CH_W'(NUM_CH))  ch_clamp = CH_W'(NUM_CH);
    end

    // Sequencer FSM with registered status and issue outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            addr          <= '0;
            start_addr    <= '0;
            ch            <= '0;
            ch_num        <= '0;
            seq_busy      <= 1'b0;
            seq_done      <= 1'b0;
            seq_err       <= 1'b0;
            dsp_cmd_start <= 1'b0;
            dsp_ch        <= '0;
        end else begin
            seq_done      <= 1'b0;
            seq_err       <= 1'b0;
            dsp_cmd_start <= 1'b0;
            if (cmd_wr_en && seq_busy) seq_err <= 1'b1;
            if (state == ST_IDLE) begin
                if (seq_start) begin
                    state      <= ST_LOAD;
                    addr       <= seq_start_addr;
                    start_addr <= seq_start_addr;
                    ch         <= '0;
                    ch_num     <= ch_clamp;
                    seq_busy   <= 1'b1;
                end
            end else begin
                if (seq_start) seq_err <= 1'b1;
                if (seq_abort) begin
                    // Abort beats any dsp_done in the same cycle
                    state    <= ST_IDLE;
                    seq_busy <= 1'b0;
                end else begin
                    case (state)
                        ST_LOAD: begin
                            state         <= ST_ISSUE;
                            dsp_cmd_start <= 1'b1;
                            dsp_ch        <= ch;
                        end
                        ST_ISSUE: state <= ST_WAIT;
                        ST_WAIT: begin
                            if (dsp_done) begin
                                if (!last) begin
                                    if (addr_inc == start_addr) begin
                                        // Walked the whole RAM without a last flag
                                        state    <= ST_IDLE;
                                        seq_busy <= 1'b0;
                                        seq_err  <= 1'b1;
                                    end else begin
                                        addr  <= addr_inc;
                                        state <= ST_LOAD;
                                    end
                                end else if (!ch_last) begin
                                    ch    <= ch + CH_W'(1);
                                    addr  <= start_addr;
                                    state <= ST_LOAD;
                                end else begin
                                    state    <= ST_IDLE;
                                    seq_busy <= 1'b0;
                                    seq_done <= 1'b1;
                                end
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_aud_cmd_seq.sv
// Bench for aud_cmd_seq: randomized command lists and DSP response delays,
// checked against a list-walking reference model.
module tb_aud_cmd_seq;

    localparam int CMD_W  = 70;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int NUM_CH = 2;
    localparam int CH_W   = 2;

    logic             clk = 0;
    logic             rst_n = 0;
    logic             cmd_wr_en = 0;
    logic [AW-1:0]    cmd_wr_addr = '0;
    logic [CMD_W:0]   cmd_wr_data = '0;
    logic             seq_start = 0;
    logic [AW-1:0]    seq_start_addr = '0;
    logic [CH_W-1:0]  seq_ch_num = '0;
    logic             seq_abort = 0;
    logic             seq_busy, seq_done, seq_err, dsp_cmd_start;
    logic [CMD_W-1:0] dsp_cmd;
    logic [CH_W-1:0]  dsp_ch;
    logic             dsp_done = 0;

    aud_cmd_seq #(.CMD_W(CMD_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_wr_en(cmd_wr_en), .cmd_wr_addr(cmd_wr_addr),
        .cmd_wr_data(cmd_wr_data), .seq_start(seq_start), .seq_start_addr(seq_start_addr),
        .seq_ch_num(seq_ch_num), .seq_abort(seq_abort), .seq_busy(seq_busy),
        .seq_done(seq_done), .seq_err(seq_err), .dsp_cmd_start(dsp_cmd_start),
        .dsp_cmd(dsp_cmd), .dsp_ch(dsp_ch), .dsp_done(dsp_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference RAM image and expected issue sequence
    logic [CMD_W:0] model_mem [DEPTH];
    int exp_addr[$];
    int exp_ch[$];
    int exp_ovr;

    // Observations from the last run
    int iss_cyc[$];
    logic [CMD_W-1:0] iss_cmd[$];
    int iss_ch[$];
    int done_cyc[$];
    int err_cyc[$];
    int end_cyc, abort_cyc, busy_at1;
    int inj_wr_addr;

    function automatic logic [CMD_W-1:0] rand_cmd();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[CMD_W-1:0];
    endfunction

    // Walk the list as the programmer sees it: per channel, from start until
    // a last flag, or until the walk comes back round to start (overrun).
    task automatic model_run(input int sa, input int chn);
        int n, a;
        exp_addr.delete(); exp_ch.delete(); exp_ovr = 0;
        n = (chn == 0) ? 1 : ((chn > NUM_CH) ? NUM_CH : chn);
        for (int c = 0; c < n && exp_ovr == 0; c++) begin
            a = sa;
            while (1) begin
                exp_addr.push_back(a);
                exp_ch.push_back(c);
                if (model_mem[a][CMD_W]) break;
                a = (a + 1) % DEPTH;
                if (a == sa) begin exp_ovr = 1; break; end
            end
        end
    endtask

    // Write len entries starting at sa (wrapping), last flag only at index last_idx (-1: none)
    task automatic write_list(input int sa, input int len, input int last_idx);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            cmd_wr_en   = 1;
            cmd_wr_addr = AW'((sa + i) % DEPTH);
            cmd_wr_data = {(i == last_idx), rand_cmd()};
            model_mem[(sa + i) % DEPTH] = cmd_wr_data;
        end
        @(posedge clk); #1;
        cmd_wr_en = 0;
    endtask

    // Start a sequence and act as the DSP. Observations sampled 1 time unit
    // after each rising edge; cycle 0 is the cycle seq_start is high.
    task automatic run_seq(input int sa, input int chn, input int fixed_dly,
                           input int abort_at, input int wr_at, input int st_at);
        int c, due, dly;
        iss_cyc.delete(); iss_cmd.delete(); iss_ch.delete();
        done_cyc.delete(); err_cyc.delete();
        end_cyc = -1; abort_cyc = -1; busy_at1 = -1; due = -1;
        @(posedge clk); #1;
        seq_start = 1; seq_start_addr = AW'(sa); seq_ch_num = CH_W'(chn);
        c = 0;
        while (1) begin
            @(posedge clk); #1;
            c++;
            seq_start = 0; seq_abort = 0; dsp_done = 0; cmd_wr_en = 0;
            if (dsp_cmd_start) begin
                iss_cyc.push_back(c); iss_cmd.push_back(dsp_cmd); iss_ch.push_back(int'(dsp_ch));
                dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 6));
                due = c + dly;
            end
            if (seq_done) done_cyc.push_back(c);
            if (seq_err) err_cyc.push_back(c);
            if (c == 1) busy_at1 = int'(seq_busy);
            if (end_cyc < 0 && c > 1 && !seq_busy) end_cyc = c;
            if (end_cyc >= 0 && c >= end_cyc + 4) break;
            if (c > 800) begin
                checks++; errors++;
                $display("FAIL run_timeout: still busy at cycle %0d, required idle", c);
                seq_abort = 1;
                break;
            end
            if (c == due) begin
                dsp_done = 1;
                if (abort_at == iss_cyc.size()) begin seq_abort = 1; abort_cyc = c; end
            end
            if (c == wr_at) begin
                cmd_wr_en = 1; cmd_wr_addr = AW'(inj_wr_addr); cmd_wr_data = {1'b1, rand_cmd()};
            end
            if (c == st_at) begin
                seq_start = 1; seq_start_addr = AW'($urandom_range(0, DEPTH - 1));
            end
        end
        @(posedge clk); #1;
        seq_start = 0; seq_abort = 0; dsp_done = 0; cmd_wr_en = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({seq_busy, seq_done, seq_err, dsp_cmd_start} !== 4'b0 || dsp_cmd !== '0 || dsp_ch !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b start=%b cmd=%h ch=%0d, required all 0",
                     seq_busy, seq_done, seq_err, dsp_cmd_start, dsp_cmd, dsp_ch);
        end
        rst_n = 1;
    endtask

    task automatic test_basic_latency();
        int exp_c[3] = '{2, 9, 16};
        write_list(0, 3, 2);
        model_run(0, 1);
        run_seq(0, 1, 5, 0, -1, -1);
        checks++;
        if (busy_at1 !== 1) begin errors++; $display("FAIL basic_busy: busy at cycle 1 = %0d, required 1", busy_at1); end
        checks++;
        if (iss_cyc.size() !== 3) begin
            errors++; $display("FAIL basic_count: %0d issues, required 3", iss_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (iss_cyc[i] !== exp_c[i] || iss_cmd[i] !== model_mem[i][CMD_W-1:0] || iss_ch[i] !== 0) begin
                    errors++;
                    $display("FAIL basic_issue%0d: cycle %0d cmd %h ch %0d, required cycle %0d cmd %h ch 0",
                             i, iss_cyc[i], iss_cmd[i], iss_ch[i], exp_c[i], model_mem[i][CMD_W-1:0]);
                end
            end
        end
        checks++;
        if (done_cyc.size() !== 1 || (done_cyc.size() == 1 && done_cyc[0] !== 22) || end_cyc !== 22 || err_cyc.size() !== 0) begin
            errors++;
            $display("FAIL basic_done: %0d done pulses, busy low at %0d, %0d errs, required one done and busy low at 22, 0 errs",
                     done_cyc.size(), end_cyc, err_cyc.size());
        end
    endtask

    task automatic test_multi_ch();
        write_list(4, 2, 1);
        model_run(4, 2);
        run_seq(4, 2, 0, 0, -1, -1);
        checks++;
        if (iss_cyc.size() !== 4) begin
            errors++; $display("FAIL multi_count: %0d issues, required 4", iss_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (iss_cmd[i] !== model_mem[exp_addr[i]][CMD_W-1:0] || iss_ch[i] !== exp_ch[i]) begin
                    errors++;
                    $display("FAIL multi_issue%0d: cmd %h ch %0d, required cmd %h ch %0d",
                             i, iss_cmd[i], iss_ch[i], model_mem[exp_addr[i]][CMD_W-1:0], exp_ch[i]);
                end
            end
        end
        checks++;
        if (done_cyc.size() !== 1 || err_cyc.size() !== 0) begin
            errors++; $display("FAIL multi_done: %0d done, %0d err, required 1 and 0", done_cyc.size(), err_cyc.size());
        end
    endtask

    task automatic test_wrap_and_overrun();
        write_list(14, 4, 3);
        model_run(14, 1);
        run_seq(14, 1, 0, 0, -1, -1);
        checks++;
        if (iss_cyc.size() !== 4) begin
            errors++; $display("FAIL wrap_count: %0d issues, required 4", iss_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (iss_cmd[i] !== model_mem[exp_addr[i]][CMD_W-1:0]) begin
                    errors++;
                    $display("FAIL wrap_issue%0d: cmd %h, required cmd %h of addr %0d",
                             i, iss_cmd[i], model_mem[exp_addr[i]][CMD_W-1:0], exp_addr[i]);
                end
            end
        end
        checks++;
        if (done_cyc.size() !== 1 || err_cyc.size() !== 0) begin
            errors++; $display("FAIL wrap_done: %0d done, %0d err, required 1 and 0", done_cyc.size(), err_cyc.size());
        end
        // No last flag anywhere: whole RAM is walked once, then overrun
        write_list(0, DEPTH, -1);
        model_run(14, 1);
        run_seq(14, 1, 0, 0, -1, -1);
        checks++;
        if (iss_cyc.size() !== exp_addr.size() || exp_addr.size() !== DEPTH) begin
            errors++; $display("FAIL ovr_count: %0d issues, required %0d", iss_cyc.size(), DEPTH);
        end
        checks++;
        if (done_cyc.size() !== 0 || err_cyc.size() !== 1 || exp_ovr !== 1) begin
            errors++; $display("FAIL ovr_err: %0d done, %0d err, required 0 and 1", done_cyc.size(), err_cyc.size());
        end
    endtask

    task automatic test_abort();
        write_list(0, 3, 2);
        run_seq(0, 1, 0, 2, -1, -1);
        checks++;
        if (iss_cyc.size() !== 2 || done_cyc.size() !== 0 || err_cyc.size() !== 0) begin
            errors++;
            $display("FAIL abort_effect: %0d issues %0d done %0d err, required 2 issues 0 done 0 err",
                     iss_cyc.size(), done_cyc.size(), err_cyc.size());
        end
        checks++;
        if (abort_cyc < 0 || end_cyc !== abort_cyc + 1) begin
            errors++; $display("FAIL abort_timing: busy low at %0d, required %0d", end_cyc, abort_cyc + 1);
        end
        // Abort while idle must not disturb a following run
        @(posedge clk); #1; seq_abort = 1;
        @(posedge clk); #1; seq_abort = 0;
        checks++;
        if (seq_busy !== 0 || seq_err !== 0) begin
            errors++; $display("FAIL abort_idle: busy=%b err=%b, required 0 0", seq_busy, seq_err);
        end
    endtask

    task automatic test_busy_errors();
        write_list(6, 3, 2);
        inj_wr_addr = 8;
        model_run(6, 1);
        run_seq(6, 1, 5, 0, 4, 6);
        checks++;
        if (err_cyc.size() !== 2 || (err_cyc.size() == 2 && (err_cyc[0] !== 5 || err_cyc[1] !== 7))) begin
            errors++; $display("FAIL busy_err: %0d err pulses, required 2 at cycles 5 and 7", err_cyc.size());
        end
        checks++;
        if (iss_cyc.size() !== 3 || done_cyc.size() !== 1) begin
            errors++; $display("FAIL busy_run: %0d issues %0d done, required 3 and 1", iss_cyc.size(), done_cyc.size());
        end else begin
            checks++;
            if (iss_cmd[2] !== model_mem[8][CMD_W-1:0]) begin
                errors++; $display("FAIL busy_wr_dropped: cmd %h, required %h", iss_cmd[2], model_mem[8][CMD_W-1:0]);
            end
        end
        // Readback run: RAM contents still the pre-run image
        run_seq(6, 1, 0, 0, -1, -1);
        checks++;
        if (iss_cyc.size() !== 3 || iss_cmd[iss_cmd.size()-1] !== model_mem[8][CMD_W-1:0]) begin
            errors++; $display("FAIL busy_readback: %0d issues, last cmd mismatch vs %h", iss_cyc.size(), model_mem[8][CMD_W-1:0]);
        end
    endtask

    task automatic test_ch_clamp();
        write_list(10, 2, 1);
        for (int k = 0; k < 2; k++) begin
            int chn;
            chn = (k == 0) ? 0 : 3;
            model_run(10, chn);
            run_seq(10, chn, 0, 0, -1, -1);
            checks++;
            if (iss_cyc.size() !== exp_addr.size() || exp_addr.size() !== (k == 0 ? 2 : 4)) begin
                errors++; $display("FAIL clamp_count ch_num=%0d: %0d issues, required %0d", chn, iss_cyc.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < iss_cyc.size(); i++) begin
                    checks++;
                    if (iss_ch[i] !== exp_ch[i] || iss_cmd[i] !== model_mem[exp_addr[i]][CMD_W-1:0]) begin
                        errors++; $display("FAIL clamp_issue ch_num=%0d idx %0d: ch %0d, required %0d", chn, i, iss_ch[i], exp_ch[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int sa, len, chn;
            sa  = int'($urandom_range(0, DEPTH - 1));
            len = int'($urandom_range(1, 5));
            chn = int'($urandom_range(0, 3));
            write_list(sa, len, len - 1);
            model_run(sa, chn);
            run_seq(sa, chn, 0, 0, -1, -1);
            checks++;
            if (iss_cyc.size() !== exp_addr.size() || done_cyc.size() !== 1 || err_cyc.size() !== 0) begin
                errors++;
                $display("FAIL rand%0d_count: %0d issues %0d done %0d err, required %0d issues 1 done 0 err",
                         r, iss_cyc.size(), done_cyc.size(), err_cyc.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < iss_cyc.size(); i++) begin
                    checks++;
                    if (iss_cmd[i] !== model_mem[exp_addr[i]][CMD_W-1:0] || iss_ch[i] !== exp_ch[i]) begin
                        errors++;
                        $display("FAIL rand%0d_issue%0d: cmd %h ch %0d, required cmd %h ch %0d",
                                 r, i, iss_cmd[i], iss_ch[i], model_mem[exp_addr[i]][CMD_W-1:0], exp_ch[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        write_list(12, 2, 1);
        @(posedge clk); #1;
        seq_start = 1; seq_start_addr = AW'(12); seq_ch_num = CH_W'(1);
        @(posedge clk); #1; seq_start = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        checks++;
        if (seq_busy !== 0 || dsp_cmd_start !== 0 || dsp_cmd !== '0) begin
            errors++; $display("FAIL rst_mid: busy=%b start=%b cmd=%h, required 0 0 0", seq_busy, dsp_cmd_start, dsp_cmd);
        end
        @(posedge clk); #1; rst_n = 1;
        model_run(12, 1);
        run_seq(12, 1, 0, 0, -1, -1);
        checks++;
        if (iss_cyc.size() !== 2 || iss_cmd[0] !== model_mem[12][CMD_W-1:0] || iss_cmd[iss_cmd.size()-1] !== model_mem[13][CMD_W-1:0]) begin
            errors++; $display("FAIL rst_ram_kept: %0d issues or payload differs from written image", iss_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_multi_ch();
        test_wrap_and_overrun();
        test_abort();
        test_busy_errors();
        test_ch_clamp();
        test_random();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
